// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder.
// Contents:
//   SLICE   - width of the shared carry-lookahead slice (matches add4)
//   state_e - controller states IDLE / RUN / DONE
//   nibbles - derives the number of slice passes for a given operand width
package adder_pkg;

  localparam int SLICE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nibbles(input int width);
    return width / SLICE;
  endfunction

  localparam int NIBBLES = nibbles(16);

endpackage

// File: rtl/add4.sv
// 4-bit carry-lookahead adder slice, purely combinational.
// Ports:
//   a, b   - 4-bit addends
//   c_in   - carry into bit 0
//   s      - 4-bit sum
//   c_out  - carry out of bit 3
module add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded directly from generate/propagate terms so no
  // ripple chain exists inside the slice.
  assign c[0]  = c_in;
  assign c[1]  = g[0] | (p[0] & c_in);
  assign c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
                 (p[2] & p[1] & p[0] & c_in);
  assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
                 (p[3] & p[2] & p[1] & g[0]) |
                 (p[3] & p[2] & p[1] & p[0] & c_in);

  assign s = p ^ c;

endmodule

// File: rtl/nibble_serial_add16.sv
// Multi-cycle WIDTH-bit add/subtract unit built around one shared 4-bit
// carry-lookahead slice. One nibble is processed per clock, LSB nibble first;
// the slice carry is registered between nibbles.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid / in_ready  - operand handshake (a, b, c_in, sub)
//   out_valid / out_ready- result handshake (sum, c_out, ovf)
//   sub                  - 1: a-b, 0: a+b+c_in (c_in ignored for sub)
//   c_out                - carry out of MSB (for sub, 1 = no borrow)
//   ovf                  - signed two's-complement overflow
//   busy                 - high while in RUN or DONE
module nibble_serial_add16
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB   = nibbles(WIDTH);
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int IDX_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   nib_cnt_q, nib_cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               c_out_q, c_out_d;
  logic               ovf_q, ovf_d;

  logic [IDX_W-1:0]   base;
  logic [SLICE-1:0]   slice_a;
  logic [SLICE-1:0]   slice_b;
  logic [SLICE-1:0]   slice_s;
  logic               slice_co;
  logic               last_nib;

  // Nibble select: the counter picks which SLICE-wide field feeds the slice.
  always_comb begin
    base    = IDX_W'(nib_cnt_q) * IDX_W'(SLICE);
    slice_a = a_q[base +: SLICE];
    slice_b = b_q[base +: SLICE];
  end

  assign last_nib = (nib_cnt_q == CNT_W'(NIB - 1));

  add4 u_add4 (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q),
    .s     (slice_s),
    .c_out (slice_co)
  );

  always_comb begin
    state_d   = state_q;
    nib_cnt_d = nib_cnt_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    c_out_d   = c_out_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1: invert b once at accept and seed the
          // carry with 1, so the slice only ever adds.
          a_d       = a;
          b_d       = sub ? ~b : b;
          carry_d   = sub ? 1'b1 : c_in;
          nib_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        sum_d[base +: SLICE] = slice_s;
        carry_d              = slice_co;
        nib_cnt_d            = nib_cnt_q + 1'b1;
        if (last_nib) begin
          c_out_d = slice_co;
          // Overflow: operands (b already inverted for sub) agree in sign
          // but the top result bit does not.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (slice_s[SLICE-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      nib_cnt_q <= '0;
      carry_q   <= 1'b0;
      sum_q     <= '0;
      c_out_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      nib_cnt_q <= nib_cnt_d;
      carry_q   <= carry_d;
      sum_q     <= sum_d;
      c_out_q   <= c_out_d;
      ovf_q     <= ovf_d;
    end
  end

  // Operand registers are only meaningful after an accept, so they carry no
  // reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  // in_ready is gated by rst_n so nothing is offered while reset is held.
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/nibble_serial_add16.md
Name: nibble_serial_add16

Overview:
Multi-cycle 16-bit add/subtract unit that time-shares a single 4-bit carry-lookahead slice (add4) across four nibbles. It processes one nibble per clock, least significant first, and registers the slice carry between nibbles. Both sides use valid/ready handshakes. It is the area-reduced alternative to the fully unrolled 16-bit adder, for datapaths that can tolerate a fixed 4-cycle compute latency.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of SLICE
SLICE, 4, slice width; fixed to match add4
NIBBLES, WIDTH/SLICE (=4), derived; number of RUN cycles

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  operands presented
in_ready  out  1  unit can accept operands
a  in  WIDTH  operand A
b  in  WIDTH  operand B
c_in  in  1  carry-in for add; ignored when sub=1
sub  in  1  1: compute a-b, 0: compute a+b+c_in
out_valid  out  1  result held valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result
c_out  out  1  carry out of MSB; for sub, 1 means no borrow
ovf  out  1  signed two's-complement overflow
busy  out  1  high in RUN or DONE

Behaviour:
- Clocking and reset: single clock, clk. rst_n is synchronous and active-low. All state updates happen on the rising edge of clk.
- Reset values: state=IDLE, nib_cnt=0, carry_reg=0. Outputs: sum=0, c_out=0, ovf=0, out_valid=0, busy=0, in_ready=0 while rst_n=0; in_ready=1 in the first cycle after release.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a_reg=a, b_reg = sub ? ~b : b, carry_reg = sub ? 1 : c_in, clear nib_cnt. Go to RUN.
- RUN:
  - In cycle k (nib_cnt=k, 0..NIBBLES-1), add4 is driven with A=a_reg[4k+3:4k], B=b_reg[4k+3:4k], C_in=carry_reg.
  - At the clock edge: sum_reg[4k+3:4k] <= S; carry_reg <= C_out; nib_cnt++.
  - in_ready=0. in_valid is ignored.
  - After the cycle with nib_cnt=NIBBLES-1: go to DONE. c_out <= final C_out. ovf <= (a_reg[MSB]==b_reg[MSB]) && (S[3]!=a_reg[MSB]).
- DONE:
  - out_valid=1. sum, c_out and ovf are held stable until out_ready=1.
  - On out_valid&&out_ready: go to IDLE, out_valid<=0. sum, c_out and ovf keep their last value.
  - No new accept in the same cycle.
- Latency: accept edge at cycle T; RUN occupies T+1..T+4; out_valid is high from T+5.
- Throughput: one operation per 6 cycles when out_ready is held at 1.
- Width rules:
  - Result is modulo 2^WIDTH.
  - Sub computes a + ~b + 1.
  - c_out=0 on sub means a<b (unsigned borrow).
- Backpressure: out_ready=0 in DONE stalls indefinitely. Outputs must not change. in_ready stays 0.
- Reset mid-operation: rst_n=0 during RUN or DONE sets IDLE and the reset values on that edge. The partial result is discarded and never signalled.
- Simultaneous events: in_valid high in any state other than IDLE has no effect. The upstream must hold operands until in_ready.
- add4 is purely combinational. The only carry path crossing the clock boundary is carry_reg.

Decomposition:
- Shared package adder_pkg contains:
  - the state enum/localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - SLICE=4 and the NIBBLES derivation.
- Sub-module: exactly one instance of the existing add4 slice, reused unmodified.
- Nibble selection is an index mux inside nibble_serial_add16; no further sub-modules.

Test Plan:
- Basic add: a=0x1234, b=0x4321, c_in=0, sub=0, out_ready=1 -> sum=0x5555, c_out=0, ovf=0. out_valid rises exactly 5 cycles after the accept edge and lasts 1 cycle.
- Full carry ripple: a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, ovf=0. Confirms carry_reg propagates across all 4 nibble cycles.
- Signed overflow: a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, ovf=1. Also a=0x8000, b=0xFFFF, c_in=0 -> sum=0x7FFF, c_out=1, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, c_in=1 (must be ignored) -> sum=0xFFFE, c_out=0, ovf=0.
- Backpressure: basic add with out_ready=0 for 3 cycles after out_valid -> sum/c_out/ovf stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE next cycle and in_ready=1.
- Reset mid-op: accept 0x00FF+0x0001, then drive rst_n=0 on the 2nd RUN cycle -> next cycle IDLE, out_valid=0, sum=0. A new op 0x0003+0x0004 then returns 0x0007.
